dsp_p_round_sat: RTL and testbench
==================================

# dsp_p_round_sat

Post-processing stage directly downstream of the DSP48A1-style multiply-accumulate slice. It tracks an issue strobe through the slice's fixed pipeline latency, captures the 48-bit P result when that strobe arrives, and scales it by an arithmetic right shift with optional rounding. It then saturates the result to a narrow signed word and queues it in a small FIFO behind a valid/ready output. It also counts results dropped on FIFO overflow.

## Interface
- P_WIDTH, 48, width of the DSP P bus.
- OUT_WIDTH, 18, signed output word width.
- SHIFT, 12, arithmetic right shift applied to P; legal range 1 to P_WIDTH-OUT_WIDTH.
- LATENCY, 4, cycles from ISSUE to a valid P; legal range 1 to 8.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- CLK  in  1  single clock; all logic is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- ISSUE  in  1  high for one cycle when the DSP is given operands whose result is wanted.
- FLUSH  in  1  synchronous clear of the in-flight pipeline and the FIFO.
- ROUND_MODE  in  1  0 = truncate, 1 = round-half-up; sampled at capture.
- P  in  P_WIDTH  DSP P output, treated as two's complement.
- OUT_DATA  out  OUT_WIDTH  head-of-FIFO word.
- OUT_OVF  out  1  saturation flag stored with the head word.
- OUT_VALID  out  1  FIFO not empty.
- OUT_READY  in  1  consumer accepts the word when OUT_VALID and OUT_READY are both high.
- DROP_CNT  out  8  number of results dropped, saturating at 255.
- BUSY  out  1  any in-flight strobe, stage-1 entry or FIFO entry.

## Operation
- **Tracker:** a LATENCY-deep valid shift register. ISSUE enters at edge k; the capture strobe is asserted during cycle k+LATENCY.
- **Stage 1 (capture edge):**
  - r = (P >>> SHIFT), sign-extended to P_WIDTH+1 bits.
  - If ROUND_MODE is 1, P[SHIFT-1] is added to r.
  - Register r and its valid bit.
- **Stage 2 (combinational into the FIFO write):**
  - r > 2^(OUT_WIDTH-1)-1 gives the max positive value with OVF=1.
  - r < -2^(OUT_WIDTH-1) gives the max negative value with OVF=1.
  - Otherwise the word is r[OUT_WIDTH-1:0] with OVF=0.
- **FIFO write:**
  - The stage-2 word is written when stage 1 is valid.
  - The write is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and DROP_CNT increments; it holds at 255.
- **FIFO read:** pop when OUT_VALID and OUT_READY are both high. Order is first-in, first-out.
- **FLUSH:**
  - Clears the tracker, stage 1 and the FIFO pointers.
  - DROP_CNT is kept.
  - An ISSUE in the same cycle is ignored, and no pop occurs.
- **Back-to-back ISSUE** every cycle is supported; throughput is one result per cycle.
- **Reset (RST_N low, asynchronous):**
  - Tracker, stage 1 and FIFO are cleared.
  - Outputs go to OUT_DATA=0, OUT_OVF=0, OUT_VALID=0, DROP_CNT=0, BUSY=0.

## Timing
- ISSUE at edge k: P is sampled at edge k+LATENCY and the FIFO is written at edge k+LATENCY+1.
- With the FIFO empty, OUT_VALID rises after edge k+LATENCY+1, so ISSUE-to-OUT_VALID is LATENCY+1 cycles.
- OUT_DATA and OUT_OVF are registered FIFO outputs, stable while OUT_VALID is high and OUT_READY is low.
- The full/empty flags update on the same edge as the push or pop. There is no bypass: a write into an empty FIFO is visible the following cycle.
- A simultaneous push and pop with the FIFO full keeps the occupancy at FIFO_DEPTH and drops nothing.
- RST_N deassertion is synchronised externally. The first ISSUE is legal on the first edge with RST_N high.

## Structure
- **Package dsp_pkg:**
  - P_WIDTH and OUT_WIDTH defaults.
  - Round-mode constants ROUND_TRUNC=0 and ROUND_HALF_UP=1.
  - Saturation limit functions sat_max(w) and sat_min(w).
- **Sub-module dsp_out_fifo:**
  - Synchronous FIFO holding {OVF, data}, parameterised by width and depth.
  - Ports: push, pop, flush, full, empty.
- **Top level:** the tracker, stage 1, the saturation logic and DROP_CNT.

## Test plan
All scenarios use the default parameters.
- **Truncate and round:** P=0x000000005800, one ISSUE. With ROUND_MODE=0, OUT_DATA=0x00005 and OVF=0. With ROUND_MODE=1, OUT_DATA=0x00006.
- **Negative rounding:** P=0xFFFFFFFFF800. With ROUND_MODE=0, OUT_DATA=0x3FFFF. With ROUND_MODE=1, OUT_DATA=0x00000. OVF=0 in both cases.
- **Saturation:** P=0xFE6FFFEC0BB1 gives OUT_DATA=0x20000 with OVF=1. P=0x00007FFFF000 gives OUT_DATA=0x1FFFF with OVF=1.
- **Latency:** ISSUE at edge 0 with OUT_READY=1. OUT_VALID is low through edge 4, high for exactly one cycle after edge 5, and BUSY is low after edge 6.
- **Overflow:**
  - OUT_READY=0 and six back-to-back ISSUEs carrying P = n<<12 for n=1..6.
  - After the pipeline drains, DROP_CNT=2.
  - Raising OUT_READY then pops 1, 2, 3, 4 in order, after which OUT_VALID=0.
- **Flush and reset:**
  - FLUSH with two words queued and one in flight: OUT_VALID=0 and BUSY=0 on the next cycle, DROP_CNT unchanged.
  - Pulling RST_N low mid-stream forces all outputs to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared defaults, rounding-mode codes and saturation limits for the DSP
// post-processing blocks.
package dsp_pkg;

    localparam int DEF_P_WIDTH   = 48;
    localparam int DEF_OUT_WIDTH = 18;

    localparam logic ROUND_TRUNC   = 1'b0;
    localparam logic ROUND_HALF_UP = 1'b1;

    // Limits of a w-bit two's complement word, widened so they compare cleanly
    // against the sign-extended stage-1 value.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/dsp_out_fifo.sv
// Small synchronous FIFO for {ovf, data} words. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module dsp_out_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW:0]                 r_wp;
    logic [AW:0]                 r_rp;
    logic                        w_pop;
    logic                        w_push;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_rdata = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
        end else if (i_flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp[AW-1:0]] <= i_wdata;
                r_wp                <= r_wp + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dsp_p_round_sat.sv
// Tracks DSP issue strobes through the slice latency, captures P, shifts and
// rounds it, saturates to a narrow word and queues it behind valid/ready.
module dsp_p_round_sat
    import dsp_pkg::*;
#(
    parameter int P_WIDTH    = DEF_P_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int SHIFT      = 12,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_issue,
    input  logic                 i_flush,
    input  logic                 i_round_mode,
    input  logic [P_WIDTH-1:0]   i_p,
    output logic [OUT_WIDTH-1:0] o_out_data,
    output logic                 o_out_ovf,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [7:0]           o_drop_cnt,
    output logic                 o_busy
);

    localparam int RW = P_WIDTH + 1;

    logic [LATENCY-1:0]    r_trk;
    logic signed [RW-1:0]  r_s1;
    logic                  r_s1_vld;
    logic [7:0]            r_drop;

    logic signed [RW-1:0]  w_shr;
    logic                  w_rnd;
    logic signed [63:0]    w_r64;
    logic [OUT_WIDTH-1:0]  w_word;
    logic                  w_ovf;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [OUT_WIDTH:0]    w_rdata;

    assign w_shr = $signed({i_p[P_WIDTH-1], i_p}) >>> SHIFT;
    assign w_rnd = (i_round_mode == ROUND_HALF_UP) ? i_p[SHIFT-1] : 1'b0;

    // Tracker and stage 1; the top tracker bit is the capture strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trk    <= '0;
            r_s1     <= '0;
            r_s1_vld <= 1'b0;
        end else if (i_flush) begin
            r_trk    <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_trk    <= (r_trk << 1) | LATENCY'(i_issue);
            r_s1_vld <= r_trk[LATENCY-1];
            if (r_trk[LATENCY-1]) begin
                r_s1 <= w_shr + $signed({{(RW-1){1'b0}}, w_rnd});
            end
        end
    end

    assign w_r64 = 64'(r_s1);

    always_comb begin
        w_word = r_s1[OUT_WIDTH-1:0];
        w_ovf  = 1'b0;
        if (w_r64 > sat_max(OUT_WIDTH)) begin
            w_word = OUT_WIDTH'(sat_max(OUT_WIDTH));
            w_ovf  = 1'b1;
        end else if (w_r64 < sat_min(OUT_WIDTH)) begin
            w_word = OUT_WIDTH'(sat_min(OUT_WIDTH));
            w_ovf  = 1'b1;
        end
    end

    assign w_pop  = o_out_valid & i_out_ready & ~i_flush;
    assign w_push = r_s1_vld & ~i_flush;
    assign w_drop = w_push & w_full & ~w_pop;

    dsp_out_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .i_wdata ({w_ovf, w_word}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Drop counter survives FLUSH; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign {o_out_ovf, o_out_data} = w_rdata;
    assign o_out_valid = ~w_empty;
    assign o_drop_cnt  = r_drop;
    assign o_busy      = (|r_trk) | r_s1_vld | ~w_empty;

endmodule

// File: tb/tb_dsp_p_round_sat.sv
// Directed bench for dsp_p_round_sat: a queue-based reference model checked
// every cycle, plus literal expectations for the hand-worked vectors.
module tb_dsp_p_round_sat;

    localparam int PW  = 48;
    localparam int OW  = 18;
    localparam int SH  = 12;
    localparam int LAT = 4;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          issue = 1'b0;
    logic          flush = 1'b0;
    logic          rm = 1'b0;
    logic          rdy = 1'b0;
    logic [PW-1:0] p = '0;
    logic [OW-1:0] o_data;
    logic          o_ovf;
    logic          o_valid;
    logic [7:0]    o_drop;
    logic          o_busy;

    always #5 clk = ~clk;

    dsp_p_round_sat #(
        .P_WIDTH(PW), .OUT_WIDTH(OW), .SHIFT(SH), .LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_issue      (issue),
        .i_flush      (flush),
        .i_round_mode (rm),
        .i_p          (p),
        .o_out_data   (o_data),
        .o_out_ovf    (o_ovf),
        .o_out_valid  (o_valid),
        .i_out_ready  (rdy),
        .o_drop_cnt   (o_drop),
        .o_busy       (o_busy)
    );

    int checks = 0;
    int passed = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [OW-1:0] d;
        logic          o;
    } word_t;

    word_t mq[$];
    int    pend[$];
    bit    s1v;
    word_t s1w;
    int    m_drop;
    int    ecnt;

    // Floor-divide by 2^SH (round-half-up biases by half a step), then clamp.
    function automatic word_t model_word(input logic [PW-1:0] pv, input logic r);
        longint step = longint'(1) << SH;
        longint lim  = longint'(1) << (OW - 1);
        longint num  = longint'($signed(pv)) + (r ? step / 2 : 0);
        longint d    = num / step;
        word_t  w;
        if (num < 0 && (num % step) != 0) d = d - 1;
        if (d > lim - 1) begin
            w.d = OW'(lim - 1); w.o = 1'b1;
        end else if (d < -lim) begin
            w.d = OW'(-lim); w.o = 1'b1;
        end else begin
            w.d = OW'(d); w.o = 1'b0;
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete(); pend.delete(); s1v = 1'b0; m_drop = 0; ecnt = 0;
        end else begin
            bit    mpop, mpush, capv;
            word_t cap;
            mpop  = (mq.size() > 0) && rdy && !flush;
            mpush = s1v && !flush;
            capv  = (pend.size() > 0) && (pend[0] + LAT == ecnt);
            cap   = model_word(p, rm);
            if (flush) begin
                mq.delete(); pend.delete(); s1v = 1'b0;
            end else begin
                if (mpop) void'(mq.pop_front());
                if (mpush) begin
                    if (mq.size() < FD) mq.push_back(s1w);
                    else if (m_drop < 255) m_drop++;
                end
                if (capv) void'(pend.pop_front());
                s1v = capv;
                s1w = cap;
                if (issue) pend.push_back(ecnt);
            end
            ecnt++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_valid", o_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("m_data", o_data, mq[0].d);
                chk("m_ovf", o_ovf, mq[0].o);
            end
            chk("m_drop", o_drop, m_drop);
            chk("m_busy", o_busy, (pend.size() > 0) || s1v || (mq.size() > 0));
        end
    end

    // ---------------- stimulus ----------------
    // P and ROUND_MODE follow ISSUE by LAT cycles, as the DSP slice would deliver them.
    logic [PW-1:0] ph[0:LAT];
    logic          rh[0:LAT];

    task automatic cyc(input bit iss, input logic [PW-1:0] pv, input bit r, input bit rd, input bit fl);
        @(negedge clk);
        for (int i = LAT; i > 0; i--) begin
            ph[i] = ph[i-1];
            rh[i] = rh[i-1];
        end
        ph[0] = pv;
        rh[0] = r;
        issue = iss;
        p     = ph[LAT];
        rm    = rh[LAT];
        rdy   = rd;
        flush = fl;
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, rd, 1'b0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !o_valid; i++) idle(1, 1'b0);
        chk("wait_valid", o_valid, 1);
    endtask

    task automatic one(input string name, input logic [PW-1:0] pv, input bit r,
                       input logic [OW-1:0] ed, input bit eo);
        cyc(1'b1, pv, r, 1'b0, 1'b0);
        wait_valid();
        chk({name, "_data"}, o_data, ed);
        chk({name, "_ovf"}, o_ovf, eo);
        idle(1, 1'b1);
        idle(2, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i <= LAT; i++) begin
            ph[i] = '0;
            rh[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #2;
        chk("rst_data", o_data, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_busy", o_busy, 0);
        mon_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        one("trunc_pos", 48'h000000005800, 1'b0, 18'h00005, 1'b0);
        one("round_pos", 48'h000000005800, 1'b1, 18'h00006, 1'b0);
        one("trunc_neg", 48'hFFFFFFFFF800, 1'b0, 18'h3FFFF, 1'b0);
        one("round_neg", 48'hFFFFFFFFF800, 1'b1, 18'h00000, 1'b0);
        one("sat_neg",   48'hFE6FFFEC0BB1, 1'b0, 18'h20000, 1'b1);
        one("sat_pos",   48'h00007FFFF000, 1'b0, 18'h1FFFF, 1'b1);
        one("edge_max",  48'h00001FFFF800, 1'b0, 18'h1FFFF, 1'b0);
        one("edge_rnd",  48'h00001FFFF800, 1'b1, 18'h1FFFF, 1'b1);

        // Latency: ISSUE lands at edge 0 with the consumer always ready.
        cyc(1'b1, 48'h000000003000, 1'b0, 1'b1, 1'b0);
        for (int e = 0; e < 8; e++) begin
            idle(1, 1'b1);
            chk($sformatf("lat_valid_e%0d", e), o_valid, (e == 5));
            if (e == 5) chk("lat_data", o_data, 18'h00003);
            if (e >= 6) chk($sformatf("lat_busy_e%0d", e), o_busy, 0);
        end

        // Overflow: six back-to-back results into a four-deep FIFO.
        for (int n = 1; n <= 6; n++) cyc(1'b1, PW'(longint'(n) << SH), 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        chk("ovf_drop", o_drop, 2);
        for (int n = 1; n <= 4; n++) begin
            chk($sformatf("ovf_pop%0d", n), o_data, n);
            idle(1, 1'b1);
            idle(1, 1'b0);
        end
        chk("ovf_empty", o_valid, 0);

        // Flush with two words queued and one in flight.
        cyc(1'b1, PW'(longint'(7) << SH), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, PW'(longint'(8) << SH), 1'b0, 1'b0, 1'b0);
        idle(7, 1'b0);
        cyc(1'b1, PW'(longint'(9) << SH), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("fl_pre_valid", o_valid, 1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("fl_valid", o_valid, 0);
        chk("fl_busy", o_busy, 0);
        chk("fl_drop", o_drop, 2);
        idle(6, 1'b0);

        // Asynchronous reset mid-stream, between clock edges.
        cyc(1'b1, PW'(longint'(10) << SH), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, PW'(longint'(11) << SH), 1'b0, 1'b0, 1'b0);
        idle(7, 1'b0);
        cyc(1'b1, PW'(longint'(12) << SH), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", o_data, 0);
        chk("arst_ovf", o_ovf, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_drop", o_drop, 0);
        chk("arst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(LAT + 1, 1'b0);

        one("post_rst", 48'h000000005800, 1'b1, 18'h00006, 1'b0);
        idle(3, 1'b1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
